clos_obuf: RTL and testbench
============================

# clos_obuf

Clocked output buffer for one Clos output port of the SDM router. It completes the 4-phase 1-of-4 handshake issued by the Clos switch's CM outputs, which feed its `di`/`di4` inputs and receive its `doa`/`doa4` acknowledges. It decodes each completed token into a binary flit and queues it in a FIFO. The FIFO drains through a synchronous valid/ready interface towards the link or the local processing element (PE).

## Interface
- `DW`, 8: data width of one virtual circuit; must be even.
- `SCN`, DW/2: number of 1-of-4 sub-channels.
- `DEPTH`, 4: FIFO entries; power of two, at least 2.

Ports:
- `clk` in 1: single clock.
- `rst` in 1: reset, asynchronous assert, active-high.
- `di` in [SCN-1:0][3:0]: 1-of-4 data from the CM output; sub-channel j, wire k high encodes value k.
- `di4` in 1: eof token wire.
- `doa` out 1: data-token acknowledge.
- `doa4` out 1: eof-token acknowledge. Only meaningful with the `CLOS_OBUF_EOF_ACK_EN` macro; see Configuration.
- `dout` out DW: head flit data.
- `deof` out 1: head flit is eof.
- `dvalid` out 1: head entry valid.
- `dready` in 1: consumer accepts the head entry.
- `err` out 1: sticky protocol-error flag.

## Operation
- **Input synchronisation.** `di` and `di4` each pass through a 2-flop synchronizer, giving `sdi` and `sdi4`. This is safe because 1-of-4 wires are monotonic within a phase.
- **Completion.** The data token is complete when every sub-channel of `sdi` is exactly one-hot and `sdi4`=0. The eof token is complete when `sdi4`=1 and all `sdi`=0.
- **Empty.** All `sdi`=0 and `sdi4`=0.
- **Error.** Any sub-channel multi-hot, or `sdi4`=1 together with any `sdi` wire high, sets `err`. `err` stays set until `rst`. An erroneous token is treated as incomplete.
- **Decode.** Sub-channel j with wire k high gives `dout[2j+1:2j]`=k.
- **FSM.**
  - IDLE: if a token is complete and count<DEPTH, push {eof, data}, go to ACK_D (data token) or ACK_E (eof token), and raise the matching ack. If the FIFO is full, stay in IDLE with acks low.
  - ACK_D / ACK_E: hold the ack high until Empty, then drop the ack and return to IDLE.
  - A token appearing in ACK_* is not sampled until after the return to IDLE.
- **FIFO.** First-word-fall-through, with circular read/write pointers that wrap modulo DEPTH.
  - Pop when `dvalid`&&`dready`.
  - Push is gated by the registered count<DEPTH. A push is not allowed when the FIFO is full, even if a pop occurs in the same cycle.
  - Simultaneous push and pop at 0<count<DEPTH leaves count unchanged.
- **Reset values.** `doa`=0, `doa4`=0, `dvalid`=0, `dout`=0, `deof`=0, `err`=0, FSM=IDLE, FIFO empty, synchronizers 0.
- **Reset mid-handshake.** Acks drop immediately and the FIFO is discarded. The upstream CM is reset by the same `rst`.

## Timing
- Wire change to synchronized: 2 `clk` edges.
- Token complete to ack high, FIFO write and `dvalid` high: 1 edge after completion is visible in `sdi`, i.e. edge 3 after the last input wire rose.
- Empty to ack low: edge 3 after the last input wire fell.
- Minimum cycle per token is 6 clocks, so throughput is at most 1 flit / 6 clk.
- `dout`/`deof` are registered from the FIFO head. They change only on a pop or on a push into an empty FIFO.
- `dvalid` drops on the edge that pops the last entry, unless a push occurs on that same edge.

## Configuration
- Macro: `CLOS_OBUF_EOF_ACK_EN`.
- **Defined:** the eof token is acknowledged on `doa4` and the data token on `doa`, matching a channel with a separate eof ack.
- **Undefined:** both token types are acknowledged on `doa`, and `doa4` is tied 0.
- FIFO and FSM behaviour are otherwise identical in both builds.

## Test plan
- **Reset.** Assert `rst` mid-ACK_D → `doa`=0 and `dvalid`=0 immediately. After release, the held token is recaptured → `doa`=1 three edges later.
- **Single data token.** DW=8, `di`={0001,0100,0010,1000} for sub-channels 0..3 → `dout`=8'hD8, `deof`=0, `doa`=1 at edge 3. Clearing `di` → `doa`=0 at edge 3.
- **eof token.** `di4`=1:
  - with the macro → `doa4`=1, `doa`=0, FIFO head `deof`=1, `dout`=0;
  - without the macro → `doa`=1, `doa4`=0.
- **Full.** Hold `dready`=0 and send 5 tokens with DEPTH=4 → the fifth `doa` stays 0. One pop → the fifth token is acked 1 edge later, FIFO order is preserved, and the pointers wrap correctly.
- **Error.** Set sub-channel 0 = 0011 → `err`=1 at edge 3, no push, no ack. Clearing the input keeps `err`=1 until `rst`.
- **Streaming.** `dready`=1 and 20 back-to-back tokens → all 20 flits delivered in order, `dvalid` never high with a stale head, and no drops.

Source files
------------

// File: rtl/clos_obuf.sv
// Clos output-port buffer: completes the 4-phase 1-of-4 handshake from a CM
// output, decodes each token into a flit and queues it in a first-word-fall-through
// FIFO drained over valid/ready.
// Build option: define CLOS_OBUF_EOF_ACK_EN to acknowledge eof tokens on doa4
// instead of doa.
module clos_obuf #(
  parameter int unsigned DW    = 8,
  parameter int unsigned SCN   = DW / 2,
  parameter int unsigned DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [SCN-1:0][3:0] di,
  input  logic                di4,
  output logic                doa,
  output logic                doa4,
  output logic [DW-1:0]       dout,
  output logic                deof,
  output logic                dvalid,
  input  logic                dready,
  output logic                err
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef enum logic [1:0] {StIdle, StAckD, StAckE} state_t;

  state_t              state_q, state_d;
  logic [SCN-1:0][3:0] di_m, sdi;
  logic                di4_m, sdi4;
  logic [SCN-1:0]      onehot, multi;
  logic [DW-1:0]       dec;
  logic                any_hi, data_done, eof_done, is_empty, proto_err;
  logic                push, pop;
  logic [DW:0]         push_word;
  logic [DW:0]         mem [DEPTH];
  logic [DW:0]         head_q, head_d;
  logic [AW-1:0]       wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]       count_q, count_d;
  logic                dvalid_q, err_q;

  // Two-flop synchronizers; 1-of-4 wires are monotonic within a phase
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      di_m  <= '0;
      sdi   <= '0;
      di4_m <= 1'b0;
      sdi4  <= 1'b0;
    end else begin
      di_m  <= di;
      sdi   <= di_m;
      di4_m <= di4;
      sdi4  <= di4_m;
    end
  end

  // Completion detection and 1-of-4 to binary decode
  always_comb begin
    onehot = '0;
    multi  = '0;
    dec    = '0;
    for (int j = 0; j < SCN; j++) begin
      onehot[j]   = sdi[j] inside {4'b0001, 4'b0010, 4'b0100, 4'b1000};
      multi[j]    = (sdi[j] != 4'b0000) && !onehot[j];
      dec[2*j+1]  = sdi[j][2] | sdi[j][3];
      dec[2*j]    = sdi[j][1] | sdi[j][3];
    end
    any_hi    = |sdi;
    data_done = (&onehot) && !sdi4;
    eof_done  = sdi4 && !any_hi;
    is_empty  = !any_hi && !sdi4;
    proto_err = (|multi) || (sdi4 && any_hi);
  end

  // eof token carries no data; dec is all zero whenever eof_done holds
  assign push_word = {eof_done, dec};

  // Handshake FSM: accept a complete token only when the FIFO has room
  always_comb begin
    state_d = state_q;
    push    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if ((data_done || eof_done) && (count_q != FULL)) begin
          push    = 1'b1;
          state_d = eof_done ? StAckE : StAckD;
        end
      end
      StAckD, StAckE: begin
        if (is_empty) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

`ifdef CLOS_OBUF_EOF_ACK_EN
  assign doa  = (state_q == StAckD);
  assign doa4 = (state_q == StAckE);
`else
  assign doa  = (state_q != StIdle);
  assign doa4 = 1'b0;
`endif

  assign pop = dvalid_q && dready;

  // Next count and registered head; head follows pops and pushes into empty
  always_comb begin
    unique case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    head_d = head_q;
    if (push && (count_q == '0)) begin
      head_d = push_word;
    end else if (pop) begin
      if (count_q > CW'(1)) head_d = mem[rd_ptr_q + AW'(1)];
      else if (push)        head_d = push_word;
    end
  end

  // FIFO storage, no reset needed: contents are qualified by count
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= push_word;
  end

  // FIFO pointers, count, head, valid and sticky error
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      head_q   <= '0;
      dvalid_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q  <= count_d;
      head_q   <= head_d;
      dvalid_q <= (count_d != '0);
      err_q    <= err_q | proto_err;
    end
  end

  assign dout   = head_q[DW-1:0];
  assign deof   = head_q[DW];
  assign dvalid = dvalid_q;
  assign err    = err_q;

endmodule

// File: tb/tb_clos_obuf.sv
// Self-checking bench for clos_obuf: directed vector table, reset/full corner
// sequences and randomized streaming against a queue-based flit model.
module tb_clos_obuf;

  localparam int unsigned DW    = 8;
  localparam int unsigned SCN   = 4;
  localparam int unsigned DEPTH = 4;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic [SCN-1:0][3:0] di_s = '0;
  logic                di4_s = 1'b0;
  logic                doa, doa4, deof, dvalid, err;
  logic                dready = 1'b0;
  logic [DW-1:0]       dout;

  int checks   = 0;
  int failures = 0;
  logic [8:0] q[$];
  logic sb_en = 1'b0;
  logic phase_done;

  typedef struct {
    logic [15:0] din;
    logic        d4;
    logic        a;
    logic        a4;
    logic [7:0]  dat;
    logic        eof;
    logic        e;
  } vec_t;
  vec_t vecs[7];

  clos_obuf #(.DW(DW), .SCN(SCN), .DEPTH(DEPTH)) dut (
    .clk    (clk),
    .rst    (rst),
    .di     (di_s),
    .di4    (di4_s),
    .doa    (doa),
    .doa4   (doa4),
    .dout   (dout),
    .deof   (deof),
    .dvalid (dvalid),
    .dready (dready),
    .err    (err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h required %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // 1-of-4 encoding: sub-channel j raises wire number d[2j+1:2j]
  function automatic logic [15:0] enc(input logic [7:0] d);
    logic [15:0] r;
    r = '0;
    for (int j = 0; j < 4; j++) r[4*j +: 4] = 4'b0001 << d[2*j +: 2];
    return r;
  endfunction

  function automatic logic ackv(input logic e);
`ifdef CLOS_OBUF_EOF_ACK_EN
    return e ? doa4 : doa;
`else
    return doa;
`endif
  endfunction

  task automatic do_reset();
    rst    = 1'b1;
    di_s   = '0;
    di4_s  = 1'b0;
    dready = 1'b0;
    q.delete();
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Full 4-phase handshake for one token; the model records the expected flit
  task automatic send_token(input logic [7:0] d, input logic e);
    logic ok;
    q.push_back({e, e ? 8'h00 : d});
    di_s  = e ? 16'h0000 : enc(d);
    di4_s = e;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (ackv(e)) begin ok = 1'b1; break; end
      tick();
    end
    chk("hs_ack_rise", 32'(ok), 32'd1);
    di_s  = '0;
    di4_s = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (!ackv(e)) begin ok = 1'b1; break; end
      tick();
    end
    chk("hs_ack_fall", 32'(ok), 32'd1);
  endtask

  // Scoreboard: every accepted head must match the oldest outstanding flit
  always @(negedge clk) begin
    if (sb_en && !rst && dvalid && dready) begin
      if (q.size() == 0) begin
        chk("sb_unexpected_flit", 32'({deof, dout}), 32'h1ff);
      end else begin
        chk("sb_flit", 32'({deof, dout}), 32'(q.pop_front()));
      end
    end
  end

  initial begin
    logic ok;
    vecs[0] = '{16'h8241, 1'b0, 1'b1, 1'b0, 8'hD8, 1'b0, 1'b0};
    vecs[1] = '{16'h1111, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0};
    vecs[2] = '{16'h8888, 1'b0, 1'b1, 1'b0, 8'hFF, 1'b0, 1'b0};
    vecs[3] = '{16'h4182, 1'b0, 1'b1, 1'b0, 8'h8D, 1'b0, 1'b0};
`ifdef CLOS_OBUF_EOF_ACK_EN
    vecs[4] = '{16'h0000, 1'b1, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0};
`else
    vecs[4] = '{16'h0000, 1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0};
`endif
    vecs[5] = '{16'h1113, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1};
    vecs[6] = '{16'h1111, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1};

    // Reset state
    do_reset();
    chk("rst_doa", 32'(doa), 32'd0);
    chk("rst_doa4", 32'(doa4), 32'd0);
    chk("rst_dvalid", 32'(dvalid), 32'd0);
    chk("rst_dout", 32'(dout), 32'd0);
    chk("rst_deof", 32'(deof), 32'd0);
    chk("rst_err", 32'(err), 32'd0);

    // Directed single-token vectors with exact edge timing
    for (int i = 0; i < 7; i++) begin
      do_reset();
      di_s  = vecs[i].din;
      di4_s = vecs[i].d4;
      tick();
      tick();
      chk("vec_ack_early", 32'({doa, doa4}), 32'd0);
      chk("vec_err_early", 32'(err), 32'd0);
      tick();
      chk("vec_doa", 32'(doa), 32'(vecs[i].a));
      chk("vec_doa4", 32'(doa4), 32'(vecs[i].a4));
      chk("vec_err", 32'(err), 32'(vecs[i].e));
      chk("vec_dvalid", 32'(dvalid), 32'(!vecs[i].e));
      if (!vecs[i].e) begin
        chk("vec_dout", 32'(dout), 32'(vecs[i].dat));
        chk("vec_deof", 32'(deof), 32'(vecs[i].eof));
      end
      di_s  = '0;
      di4_s = 1'b0;
      tick();
      tick();
      chk("vec_ack_hold", 32'({doa, doa4}), 32'({vecs[i].a, vecs[i].a4}));
      tick();
      chk("vec_ack_drop", 32'({doa, doa4}), 32'd0);
      chk("vec_err_sticky", 32'(err), 32'(vecs[i].e));
      if (!vecs[i].e) begin
        dready = 1'b1;
        tick();
        dready = 1'b0;
        chk("vec_pop_dvalid", 32'(dvalid), 32'd0);
      end
    end

    // Reset in the middle of an acknowledged data token
    do_reset();
    di_s = 16'h8241;
    tick();
    tick();
    tick();
    chk("midrst_doa_before", 32'(doa), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_doa", 32'(doa), 32'd0);
    chk("midrst_dvalid", 32'(dvalid), 32'd0);
    tick();
    rst = 1'b0;
    tick();
    tick();
    chk("midrst_recap_early", 32'(doa), 32'd0);
    tick();
    chk("midrst_recap", 32'(doa), 32'd1);
    chk("midrst_dout", 32'(dout), 32'hD8);
    di_s = '0;
    tick();
    tick();
    tick();

    // Full FIFO: fifth token waits until one pop frees a slot
    do_reset();
    sb_en = 1'b1;
    send_token(8'h11, 1'b0);
    send_token(8'h22, 1'b0);
    send_token(8'h33, 1'b0);
    send_token(8'h44, 1'b0);
    q.push_back({1'b0, 8'h55});
    di_s = enc(8'h55);
    for (int i = 0; i < 10; i++) tick();
    chk("full_no_ack", 32'(doa), 32'd0);
    chk("full_head", 32'(dout), 32'h11);
    dready = 1'b1;
    tick();
    dready = 1'b0;
    chk("full_ack_after_pop_early", 32'(doa), 32'd0);
    chk("full_new_head", 32'(dout), 32'h22);
    tick();
    chk("full_ack_after_pop", 32'(doa), 32'd1);
    di_s = '0;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (!doa) begin ok = 1'b1; break; end
      tick();
    end
    chk("full_ack_fall", 32'(ok), 32'd1);
    dready = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (!dvalid) begin ok = 1'b1; break; end
      tick();
    end
    dready = 1'b0;
    chk("full_drain", 32'(ok), 32'd1);
    chk("full_all_delivered", 32'(q.size()), 32'd0);

    // Streaming with the consumer always ready
    dready = 1'b1;
    for (int n = 0; n < 20; n++) send_token(8'($urandom), $urandom_range(0, 4) == 0);
    for (int i = 0; i < 10; i++) tick();
    chk("stream_delivered", 32'(q.size()), 32'd0);
    chk("stream_dvalid_idle", 32'(dvalid), 32'd0);

    // Randomized consumer back-pressure
    phase_done = 1'b0;
    fork
      begin
        for (int n = 0; n < 16; n++) send_token(8'($urandom), $urandom_range(0, 3) == 0);
        phase_done = 1'b1;
      end
      begin
        while (!phase_done) begin
          dready = ($urandom_range(0, 2) == 0);
          tick();
        end
      end
    join
    dready = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (!dvalid) begin ok = 1'b1; break; end
      tick();
    end
    chk("rand_drain", 32'(ok), 32'd1);
    chk("rand_delivered", 32'(q.size()), 32'd0);
    chk("rand_no_err", 32'(err), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
